// File: rtl/modbus_pkg.sv
// rtl/modbus_pkg.sv - shared MODBUS RTU constants and frame-state encoding
package modbus_pkg;

   localparam logic [15:0] CRC_POLY   = 16'hA001;
   localparam logic [15:0] CRC_INIT   = 16'hFFFF;
   localparam logic [7:0]  BCAST_ADDR = 8'h00;

   typedef enum logic [2:0] {
      STARTUP,
      IDLE,
      RECEIVE,
      CHECK,
      DRAIN
   } frame_state_e;

endpackage

// File: rtl/modbus_crc16_step.sv
// rtl/modbus_crc16_step.sv - combinational byte-wise CRC-16/MODBUS update (reflected, LSB first)
module modbus_crc16_step
   import modbus_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [15:0] crc_out
);

   logic [15:0] c;

   always_comb begin
      c = crc_in ^ {8'h00, data_in};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      crc_out = c;
   end

endmodule

// File: rtl/modbus_rtu_rx_framer.sv
// rtl/modbus_rtu_rx_framer.sv - MODBUS RTU receive framer: silence delimiting, CRC/length/address check, CRC-stripped drain
// Optional frame counters (stat_ok, stat_crc_err, stat_drop) when MODBUS_RX_STATS_EN is defined.
module modbus_rtu_rx_framer
   import modbus_pkg::*;
#(
   parameter int          T15_CYCLES = 42969,
   parameter int          T35_CYCLES = 100260,
   parameter int          MAX_FRAME  = 16,
   parameter logic [7:0]  SLAVE_ADDR = 8'h01
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        rx_err,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        out_bcast,
   output logic        busy
`ifdef MODBUS_RX_STATS_EN
   ,
   output logic [15:0] stat_ok,
   output logic [15:0] stat_crc_err,
   output logic [15:0] stat_drop
`endif
);

   localparam int GAP_W = $clog2(T35_CYCLES + 1);
   localparam int IDX_W = $clog2(MAX_FRAME + 1);
   localparam int AW    = $clog2(MAX_FRAME);
   localparam logic [GAP_W-1:0] T15_G = GAP_W'(T15_CYCLES);
   localparam logic [GAP_W-1:0] T35_G = GAP_W'(T35_CYCLES);
   localparam logic [IDX_W-1:0] MAX_I = IDX_W'(MAX_FRAME);
   localparam logic [IDX_W-1:0] MIN_I = IDX_W'(4);

   frame_state_e     state, state_next;
   logic [GAP_W-1:0] gap_cnt;
   logic [IDX_W-1:0] idx, rd, len;
   logic [15:0]      crc, crc_next;
   logic             bad;
   logic             bcast_q;
   logic             busy_q;
   logic [7:0]       frame_buf [MAX_FRAME];

   logic wr_en, bad_set, accept, frame_clr, xfer;
   logic gap_full, frame_ok, last_beat;

   modbus_crc16_step u_crc (
      .crc_in  (crc),
      .data_in (rx_data),
      .crc_out (crc_next)
   );

   assign gap_full  = (gap_cnt == T35_G);
   assign last_beat = (rd == len - IDX_W'(1));
   // Residue over the whole frame including its CRC is zero for an intact frame.
   assign frame_ok  = !bad && (idx >= MIN_I) && (crc == 16'h0000) &&
                      ((frame_buf[0] == SLAVE_ADDR) || (frame_buf[0] == BCAST_ADDR));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= STARTUP;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      wr_en      = 1'b0;
      bad_set    = 1'b0;
      accept     = 1'b0;
      frame_clr  = 1'b0;
      xfer       = 1'b0;
      case (state)
         STARTUP: if (gap_full) state_next = IDLE;
         IDLE: begin
            if (rx_valid) begin
               wr_en      = 1'b1;
               bad_set    = rx_err;
               state_next = RECEIVE;
            end
         end
         RECEIVE: begin
            if (gap_full) begin
               state_next = CHECK;
            end else if (rx_valid) begin
               wr_en   = (idx != MAX_I);
               bad_set = (idx == MAX_I) || (gap_cnt >= T15_G) || rx_err;
            end
         end
         CHECK: begin
            if (frame_ok) begin
               accept     = 1'b1;
               state_next = DRAIN;
            end else begin
               frame_clr  = 1'b1;
               state_next = IDLE;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               xfer = 1'b1;
               if (last_beat) begin
                  frame_clr  = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = STARTUP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt <= '0;
         idx     <= '0;
         rd      <= '0;
         len     <= '0;
         crc     <= CRC_INIT;
         bad     <= 1'b0;
         bcast_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         busy_q <= (state_next != IDLE);
         if (rx_valid)      gap_cnt <= '0;
         else if (!gap_full) gap_cnt <= gap_cnt + GAP_W'(1);
         if (frame_clr) begin
            idx     <= '0;
            rd      <= '0;
            crc     <= CRC_INIT;
            bad     <= 1'b0;
            bcast_q <= 1'b0;
         end else begin
            if (wr_en) begin
               idx <= idx + IDX_W'(1);
               crc <= crc_next;
            end
            if (bad_set) bad <= 1'b1;
            if (accept) begin
               len     <= idx - IDX_W'(2);
               bcast_q <= (frame_buf[0] == BCAST_ADDR);
            end
            if (xfer) rd <= rd + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) frame_buf[idx[AW-1:0]] <= rx_data;
   end

   assign out_valid = (state == DRAIN);
   assign out_data  = out_valid ? frame_buf[rd[AW-1:0]] : 8'h00;
   assign out_last  = out_valid && last_beat;
   assign out_bcast = bcast_q;
   assign busy      = busy_q;

`ifdef MODBUS_RX_STATS_EN
   logic crc_fail, drop_ev;

   assign crc_fail = (state == CHECK) && !bad && (idx >= MIN_I) && (crc != 16'h0000);
   // Bytes arriving while draining are lost and counted with the dropped frames.
   assign drop_ev  = ((state == CHECK) && (bad || (idx < MIN_I))) ||
                     ((state == DRAIN) && rx_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_ok      <= '0;
         stat_crc_err <= '0;
         stat_drop    <= '0;
      end else begin
         if (accept && (stat_ok != 16'hFFFF))        stat_ok      <= stat_ok + 16'd1;
         if (crc_fail && (stat_crc_err != 16'hFFFF)) stat_crc_err <= stat_crc_err + 16'd1;
         if (drop_ev && (stat_drop != 16'hFFFF))     stat_drop    <= stat_drop + 16'd1;
      end
   end
`endif

endmodule
